// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch FSM with stall hold, branch redirect and optional fetch timeout
// Optional feature macro: FETCH_TIMEOUT_EN (memory-wait watchdog with sticky fault)
module instruction_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] PC_STEP        = 32'd4,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_add_bus,
    output logic        mem_rd,
    input  logic [31:0] mem_data,
    input  logic        mem_ready,
    input  logic        stall,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [3:0]  op_code,
    output logic        instr_valid,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_instr, w_instr_next;
    logic        r_valid, w_valid_next;
    logic        r_mem_rd, w_mem_rd_next;
    logic [31:0] w_branch_pc;

    // Redirect targets are word aligned regardless of the low address bits supplied.
    assign w_branch_pc = {branch_target[31:2], 2'b00};

`ifdef FETCH_TIMEOUT_EN
    logic [31:0] r_tmo_cnt, w_tmo_cnt_next;
    logic        r_fault, w_fault_next;
`else
    logic        w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_instr_next  = r_instr;
        w_valid_next  = r_valid;
        w_mem_rd_next = r_mem_rd;
`ifdef FETCH_TIMEOUT_EN
        w_tmo_cnt_next = 32'd0;
        w_fault_next   = r_fault;
`endif
        case (r_state)
            S_REQ: begin
                if (branch_en) begin
                    w_pc_next     = w_branch_pc;
                    w_valid_next  = 1'b0;
                    w_mem_rd_next = 1'b0;
                end else if (r_mem_rd && mem_ready) begin
                    w_instr_next  = mem_data;
                    w_valid_next  = 1'b1;
                    w_mem_rd_next = 1'b0;
                    w_state_next  = S_HOLD;
                end else begin
                    w_valid_next  = 1'b0;
                    w_mem_rd_next = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    if ((r_tmo_cnt + 32'd1) == TIMEOUT_CYCLES) begin
                        w_fault_next  = 1'b1;
                        w_mem_rd_next = 1'b0;
                        w_state_next  = S_FAULT;
                    end else begin
                        w_tmo_cnt_next = r_tmo_cnt + 32'd1;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (branch_en) begin
                    w_pc_next     = w_branch_pc;
                    w_valid_next  = 1'b0;
                    w_mem_rd_next = 1'b0;
                    w_state_next  = S_REQ;
                end else if (!stall) begin
                    // Request the next word in the same edge so REQ starts with mem_rd already high.
                    w_pc_next     = r_pc + PC_STEP;
                    w_valid_next  = 1'b0;
                    w_mem_rd_next = 1'b1;
                    w_state_next  = S_REQ;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            S_FAULT: begin
                w_valid_next  = 1'b0;
                w_mem_rd_next = 1'b0;
            end
`endif
            default: begin
                w_valid_next  = 1'b0;
                w_mem_rd_next = 1'b0;
                w_state_next  = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_instr  <= 32'd0;
            r_valid  <= 1'b0;
            r_mem_rd <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_instr  <= w_instr_next;
            r_valid  <= w_valid_next;
            r_mem_rd <= w_mem_rd_next;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= 32'd0;
            r_fault   <= 1'b0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_next;
            r_fault   <= w_fault_next;
        end
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    assign mem_add_bus = r_pc;
    assign mem_rd      = r_mem_rd;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign op_code     = r_instr[31:28];
    assign instr_valid = r_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] mem_add_bus;
    logic        mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        stall;
    logic        branch_en;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  op_code;
    logic        instr_valid;
    logic        fault;

    int tests_run = 0;
    int tests_failed = 0;

    instruction_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .mem_add_bus   (mem_add_bus),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .pc            (pc),
        .instr         (instr),
        .op_code       (op_code),
        .instr_valid   (instr_valid),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; mem_data = 32'd0; mem_ready = 1'b0; stall = 1'b0;
        branch_en = 1'b0; branch_target = 32'd0;
        tick(); tick();
        check("rst_pc", pc, 32'h0);
        check("rst_addr", mem_add_bus, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);

        rst = 1'b0;
        tick();
        check("rd_rise", {31'd0, mem_rd}, 32'd1);
        check("rd_rise_valid", {31'd0, instr_valid}, 32'd0);

        mem_ready = 1'b1; mem_data = 32'hD000_0010;
        tick();
        check("fetch_valid", {31'd0, instr_valid}, 32'd1);
        check("fetch_instr", instr, 32'hD000_0010);
        check("fetch_op", {28'd0, op_code}, 32'hD);
        check("fetch_pc", pc, 32'h0);
        check("fetch_rd_low", {31'd0, mem_rd}, 32'd0);

        // Stall for five cycles; a stray mem_ready in HOLD must be ignored.
        stall = 1'b1; mem_ready = 1'b1; mem_data = 32'hABCD_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            mem_ready = 1'b0;
            check("stall_instr", instr, 32'hD000_0010);
            check("stall_pc", pc, 32'h0);
            check("stall_op", {28'd0, op_code}, 32'hD);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        tick();
        check("adv_pc", pc, 32'h4);
        check("adv_addr", mem_add_bus, 32'h4);
        check("adv_valid", {31'd0, instr_valid}, 32'd0);
        check("adv_rd", {31'd0, mem_rd}, 32'd1);

        branch_en = 1'b1; branch_target = 32'h0000_0103;
        mem_ready = 1'b1; mem_data = 32'h1234_5678;
        tick();
        check("br_addr", mem_add_bus, 32'h0000_0100);
        check("br_valid", {31'd0, instr_valid}, 32'd0);
        check("br_instr_kept", instr, 32'hD000_0010);
        check("br_rd", {31'd0, mem_rd}, 32'd0);
        branch_en = 1'b0; mem_ready = 1'b0;
        tick();
        check("br_rd_rise", {31'd0, mem_rd}, 32'd1);

        mem_ready = 1'b1; mem_data = 32'h7000_00AA;
        tick();
        check("f2_op", {28'd0, op_code}, 32'h7);
        check("f2_pc", pc, 32'h0000_0100);

        // Branch during stall in HOLD wins.
        mem_ready = 1'b0; stall = 1'b1; branch_en = 1'b1; branch_target = 32'hFFFF_FFFE;
        tick();
        check("brstall_pc", pc, 32'hFFFF_FFFC);
        check("brstall_valid", {31'd0, instr_valid}, 32'd0);
        branch_en = 1'b0; stall = 1'b0;
        tick();
        mem_ready = 1'b1; mem_data = 32'h1111_1111;
        tick();
        check("f3_valid", {31'd0, instr_valid}, 32'd1);
        check("f3_pc", pc, 32'hFFFF_FFFC);
        mem_ready = 1'b0;
        tick();
        check("wrap_addr", mem_add_bus, 32'h0);
        check("wrap_rd", {31'd0, mem_rd}, 32'd1);

        // Reset mid-wait, with a branch asserted in the same cycle.
        branch_en = 1'b1; branch_target = 32'h0000_0200;
        tick();
        branch_en = 1'b0;
        tick(); tick();
        check("wait_pc", pc, 32'h0000_0200);
        rst = 1'b1; branch_en = 1'b1; branch_target = 32'h0000_0300;
        tick();
        check("rstmid_pc", pc, 32'h0);
        check("rstmid_valid", {31'd0, instr_valid}, 32'd0);
        check("rstmid_rd", {31'd0, mem_rd}, 32'd0);
        rst = 1'b0; branch_en = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 14; i++) tick();
        check("tmo_pre_fault", {31'd0, fault}, 32'd0);
        tick();
        check("tmo_fault", {31'd0, fault}, 32'd1);
        check("tmo_rd", {31'd0, mem_rd}, 32'd0);
        branch_en = 1'b1; branch_target = 32'h0000_0400;
        tick(); tick();
        branch_en = 1'b0;
        check("tmo_br_ignored", pc, 32'h0);
        check("tmo_sticky", {31'd0, fault}, 32'd1);
        check("tmo_rd_low", {31'd0, mem_rd}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("tmo_rst_clear", {31'd0, fault}, 32'd0);
`else
        for (int i = 0; i < 20; i++) tick();
        check("nowd_fault", {31'd0, fault}, 32'd0);
        check("nowd_rd", {31'd0, mem_rd}, 32'd1);
        mem_ready = 1'b1; mem_data = 32'h5000_0001;
        tick();
        mem_ready = 1'b0;
        check("nowd_late_op", {28'd0, op_code}, 32'h5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
